// File: rtl/hv_dac_scheduler_pkg.sv
// Shared definitions for the HV DAC scheduler: FSM encoding, timeout error code,
// default parameter values and a counter-width helper.
package hv_dac_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  localparam logic [7:0] ERR_TIMEOUT = 8'hFF;

  localparam int NCH_DEF        = 8;
  localparam int DW_DEF         = 10;
  localparam int REFRESH_W_DEF  = 20;
  localparam int START_HOLD_DEF = 8;
  localparam int TIMEOUT_DEF    = 4096;
  localparam int MAX_RETRY_DEF  = 3;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hv_shadow_ram.sv
// NCH x DW shadow table of DAC codes: one synchronous write port, one
// combinational read port. Cleared on reset so the HV outputs come up at zero.
module hv_shadow_ram
  import hv_dac_scheduler_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int DW  = DW_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    we_i,
  input  logic [$clog2(NCH)-1:0]  waddr_i,
  input  logic [DW-1:0]           wdata_i,
  input  logic [$clog2(NCH)-1:0]  raddr_i,
  output logic [DW-1:0]           rdata_o
);

  logic [DW-1:0] mem_q [NCH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NCH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/hv_dac_scheduler.sv
// Sequencer for the 8-channel HV DAC driver: owns the shadow code table, launches
// update sequences on host writes or periodic refresh, retries on readback errors.
module hv_dac_scheduler
  import hv_dac_scheduler_pkg::*;
#(
  parameter int NCH        = NCH_DEF,
  parameter int DW         = DW_DEF,
  parameter int REFRESH_W  = REFRESH_W_DEF,
  parameter int START_HOLD = START_HOLD_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF,
  parameter int MAX_RETRY  = MAX_RETRY_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    host_we,
  input  logic [$clog2(NCH)-1:0]  host_ch,
  input  logic [DW-1:0]           host_data,
  output logic                    host_ack,
  input  logic                    refresh_en,
  input  logic                    fault_clr,
  input  logic [$clog2(NCH)-1:0]  f_cnt,
  input  logic                    dac_end,
  input  logic [7:0]              dac_err_reg,
  output logic [DW-1:0]           ram_data_out,
  output logic                    hv_start,
  output logic                    busy,
  output logic                    fault,
  output logic [7:0]              err_code,
  output logic [1:0]              retry_cnt,
  output logic                    upd_done
);

  localparam int HW = cnt_width(START_HOLD);
  localparam int TW = cnt_width(TIMEOUT);
  localparam logic [HW-1:0] HOLD_LAST = HW'(START_HOLD - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRY);

  state_t               state_q, state_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic [1:0]           retry_q, retry_d;
  logic [7:0]           err_q, err_d;
  logic                 upd_q, upd_d;
  logic                 ack_q, ack_d;
  logic                 dirty_q, dirty_d;
  logic                 pend_q, pend_d;
  logic [REFRESH_W-1:0] rcnt_q, rcnt_d;
  logic                 dac_end_q;

  logic wr_acc;
  logic go_start;
  logic seq_end;
  logic fail;
  logic end_rise;
  logic wrap;

  // A write is taken only while the driver is idle or faulted; the pending ack
  // masks the held request so one host transaction commits exactly once.
  assign wr_acc   = host_we && !ack_q && (state_q == ST_IDLE || state_q == ST_FAULT);
  assign end_rise = dac_end && !dac_end_q;
  assign wrap     = refresh_en && (&rcnt_q);

  hv_shadow_ram #(
    .NCH (NCH),
    .DW  (DW)
  ) u_shadow (
    .clk_i   (clk),
    .rst_ni  (reset),
    .we_i    (wr_acc),
    .waddr_i (host_ch),
    .wdata_i (host_data),
    .raddr_i (f_cnt),
    .rdata_o (ram_data_out)
  );

  always_comb begin
    state_d  = state_q;
    retry_d  = retry_q;
    err_d    = err_q;
    upd_d    = 1'b0;
    go_start = 1'b0;
    seq_end  = 1'b0;
    fail     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A write in flight (accepted now or being acked) wins over launching.
        if ((dirty_q || pend_q) && !ack_q && !wr_acc) begin
          state_d  = ST_START;
          retry_d  = '0;
          go_start = 1'b1;
        end
      end
      ST_START: begin
        if (hold_q == HOLD_LAST) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (end_rise) begin
          state_d = ST_CHECK;
        end else if (tmo_q == TMO_LAST) begin
          err_d = ERR_TIMEOUT;
          fail  = 1'b1;
        end
      end
      ST_CHECK: begin
        err_d = dac_err_reg;
        if (dac_err_reg == 8'h00) begin
          upd_d   = 1'b1;
          seq_end = 1'b1;
          state_d = ST_IDLE;
        end else begin
          fail = 1'b1;
        end
      end
      ST_FAULT: begin
        if (fault_clr) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (fail) begin
      if (retry_q < RETRY_MAX) begin
        retry_d = retry_q + 2'd1;
        state_d = ST_START;
      end else begin
        state_d = ST_FAULT;
        seq_end = 1'b1;
      end
    end

    // Timeout spans START and WAIT and restarts on every (re)entry to START.
    if (state_d == ST_START && state_q != ST_START) begin
      tmo_d = '0;
    end else if (state_q == ST_START || state_q == ST_WAIT) begin
      tmo_d = tmo_q + 1'b1;
    end else begin
      tmo_d = '0;
    end

    hold_d = (state_q == ST_START && state_d == ST_START) ? hold_q + 1'b1 : '0;
  end

  assign ack_d   = wr_acc;
  assign dirty_d = wr_acc || (dirty_q && !go_start);
  assign pend_d  = wrap || (pend_q && !go_start);

  always_comb begin
    rcnt_d = rcnt_q;
    if (seq_end) begin
      rcnt_d = '0;
    end else if (refresh_en) begin
      rcnt_d = rcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      tmo_q     <= '0;
      retry_q   <= '0;
      err_q     <= '0;
      upd_q     <= 1'b0;
      ack_q     <= 1'b0;
      dirty_q   <= 1'b0;
      pend_q    <= 1'b0;
      rcnt_q    <= '0;
      dac_end_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      tmo_q     <= tmo_d;
      retry_q   <= retry_d;
      err_q     <= err_d;
      upd_q     <= upd_d;
      ack_q     <= ack_d;
      dirty_q   <= dirty_d;
      pend_q    <= pend_d;
      rcnt_q    <= rcnt_d;
      dac_end_q <= dac_end;
    end
  end

  // Decoded straight from the async-reset state flop so hv_start drops with reset.
  assign hv_start  = (state_q == ST_START);
  assign busy      = (state_q == ST_START) || (state_q == ST_WAIT) || (state_q == ST_CHECK);
  assign fault     = (state_q == ST_FAULT);
  assign host_ack  = ack_q;
  assign err_code  = err_q;
  assign retry_cnt = retry_q;
  assign upd_done  = upd_q;

endmodule

// File: tb/tb_hv_dac_scheduler.sv
// Directed bench for hv_dac_scheduler: host writes, retry/fault, timeout,
// refresh, stalled writes and reset mid-sequence.
module tb_hv_dac_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       host_we;
  logic [2:0] host_ch;
  logic [9:0] host_data;
  logic       host_ack;
  logic       refresh_en;
  logic       fault_clr;
  logic [2:0] f_cnt;
  logic       dac_end;
  logic [7:0] dac_err_reg;
  logic [9:0] ram_data_out;
  logic       hv_start;
  logic       busy;
  logic       fault;
  logic [7:0] err_code;
  logic [1:0] retry_cnt;
  logic       upd_done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hv_dac_scheduler #(.REFRESH_W(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .host_we      (host_we),
    .host_ch      (host_ch),
    .host_data    (host_data),
    .host_ack     (host_ack),
    .refresh_en   (refresh_en),
    .fault_clr    (fault_clr),
    .f_cnt        (f_cnt),
    .dac_end      (dac_end),
    .dac_err_reg  (dac_err_reg),
    .ram_data_out (ram_data_out),
    .hv_start     (hv_start),
    .busy         (busy),
    .fault        (fault),
    .err_code     (err_code),
    .retry_cnt    (retry_cnt),
    .upd_done     (upd_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [2:0] ch, input logic [9:0] d);
    host_ch   = ch;
    host_data = d;
    host_we   = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (host_ack === 1'b1) break;
    end
    host_we = 1'b0;
  endtask

  // Wait for a launch and for the driver to enter WAIT (hv_start falling).
  task automatic wait_wait(output bit ok);
    int n = 0;
    while (hv_start !== 1'b1 && n < 100) begin tick(); n++; end
    while (hv_start === 1'b1 && n < 100) begin tick(); n++; end
    ok = (n < 100);
  endtask

  // Driver reports end of sequence with the given readback errors; returns after CHECK.
  task automatic finish_seq(input logic [7:0] err);
    dac_err_reg = err;
    dac_end     = 1'b1;
    tick();
    dac_end = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; host_we = 1'b0; host_ch = '0; host_data = '0; refresh_en = 1'b0;
    fault_clr = 1'b0; f_cnt = '0; dac_end = 1'b0; dac_err_reg = '0;
    tick(); tick();
    tests++;
    if ({hv_start, busy, fault, host_ack, upd_done, err_code, retry_cnt, ram_data_out} !== 25'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h required 0",
               {hv_start, busy, fault, host_ack, upd_done, err_code, retry_cnt, ram_data_out});
    end
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      f_cnt = 3'(c);
      #1;
      tests++;
      if (ram_data_out !== 10'h000) begin
        fails++;
        $display("FAIL reset_shadow ch%0d: got %h required 000", c, ram_data_out);
      end
    end
    tick(); tick();
    tests++;
    if (busy !== 1'b0 || hv_start !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: got busy=%b hv_start=%b required 0 0", busy, hv_start);
    end
  endtask

  task automatic test_write_update();
    int hi;
    f_cnt = 3'd5; host_ch = 3'd5; host_data = 10'h2A5; host_we = 1'b1;
    tick();
    tests++;
    if (host_ack !== 1'b1) begin fails++; $display("FAIL t1_ack: got %b required 1", host_ack); end
    tests++;
    if (ram_data_out !== 10'h2A5) begin fails++; $display("FAIL t1_shadow: got %h required 2a5", ram_data_out); end
    tests++;
    if (hv_start !== 1'b0) begin fails++; $display("FAIL t1_no_start_on_ack: got %b required 0", hv_start); end
    host_we = 1'b0;
    tick();
    tests++;
    if (host_ack !== 1'b0 || hv_start !== 1'b0) begin
      fails++; $display("FAIL t1_ack_pulse: got ack=%b hv=%b required 0 0", host_ack, hv_start);
    end
    tick();
    tests++;
    if (hv_start !== 1'b1 || busy !== 1'b1) begin
      fails++; $display("FAIL t1_launch: got hv=%b busy=%b required 1 1", hv_start, busy);
    end
    hi = 0;
    while (hv_start === 1'b1 && hi < 20) begin hi++; tick(); end
    tests++;
    if (hi !== 8) begin fails++; $display("FAIL t1_hold: got %0d cycles required 8", hi); end
    finish_seq(8'h00);
    tests++;
    if ({upd_done, busy, err_code, retry_cnt} !== {1'b1, 1'b0, 8'h00, 2'd0}) begin
      fails++;
      $display("FAIL t1_done: got upd=%b busy=%b err=%h retry=%0d required 1 0 00 0",
               upd_done, busy, err_code, retry_cnt);
    end
    tick();
    tests++;
    if (upd_done !== 1'b0) begin fails++; $display("FAIL t1_done_pulse: got %b required 0", upd_done); end
  endtask

  task automatic test_retry_fault();
    bit ok;
    do_write(3'd1, 10'h155);
    for (int k = 0; k < 4; k++) begin
      wait_wait(ok);
      tests++;
      if (!ok) begin fails++; $display("FAIL t2_launch%0d: got no sequence required launch", k); end
      finish_seq(8'h04);
      if (k < 3) begin
        tests++;
        if ({retry_cnt, hv_start, fault} !== {2'(k + 1), 1'b1, 1'b0}) begin
          fails++;
          $display("FAIL t2_retry%0d: got retry=%0d hv=%b fault=%b required %0d 1 0",
                   k, retry_cnt, hv_start, fault, k + 1);
        end
      end
    end
    tests++;
    if ({fault, retry_cnt, err_code, hv_start, busy} !== {1'b1, 2'd3, 8'h04, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL t2_fault: got fault=%b retry=%0d err=%h hv=%b busy=%b required 1 3 04 0 0",
               fault, retry_cnt, err_code, hv_start, busy);
    end
    tick(); tick();
    tests++;
    if (fault !== 1'b1 || hv_start !== 1'b0) begin
      fails++; $display("FAIL t2_fault_hold: got fault=%b hv=%b required 1 0", fault, hv_start);
    end
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    tests++;
    if ({fault, busy, retry_cnt} !== {1'b0, 1'b0, 2'd3}) begin
      fails++; $display("FAIL t2_clear: got fault=%b busy=%b retry=%0d required 0 0 3", fault, busy, retry_cnt);
    end
    tick(); tick(); tick();
    tests++;
    if (hv_start !== 1'b0) begin fails++; $display("FAIL t2_idle_after_clr: got hv=%b required 0", hv_start); end
  endtask

  task automatic test_timeout();
    int  cnt;
    logic prev;
    dac_end = 1'b1;
    tick(); tick();
    do_write(3'd0, 10'h0F0);
    cnt = 0;
    while (hv_start !== 1'b1 && cnt < 10) begin tick(); cnt++; end
    for (int r = 0; r < 3; r++) begin
      prev = hv_start;
      tick();
      cnt = 1;
      while (!(hv_start === 1'b1 && prev === 1'b0) && cnt < 5000) begin
        prev = hv_start; tick(); cnt++;
      end
      tests++;
      if (cnt !== 4096 || retry_cnt !== 2'(r + 1)) begin
        fails++;
        $display("FAIL t3_relaunch%0d: got %0d clk retry=%0d required 4096 clk retry=%0d",
                 r, cnt, retry_cnt, r + 1);
      end
    end
    cnt = 0;
    while (fault !== 1'b1 && cnt < 5000) begin tick(); cnt++; end
    tests++;
    if ({fault, err_code, retry_cnt} !== {1'b1, 8'hFF, 2'd3} || cnt !== 4096) begin
      fails++;
      $display("FAIL t3_fault: got fault=%b err=%h retry=%0d after %0d clk required 1 ff 3 after 4096",
               fault, err_code, retry_cnt, cnt);
    end
    dac_end = 1'b0;
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
  endtask

  task automatic test_refresh();
    int cnt;
    bit ok;
    refresh_en = 1'b1;
    cnt = 0;
    while (hv_start !== 1'b1 && cnt < 200) begin tick(); cnt++; end
    tests++;
    if (cnt !== 65) begin fails++; $display("FAIL t4_first_tick: got %0d clk required 65", cnt); end
    wait_wait(ok);
    finish_seq(8'h00);
    tests++;
    if (upd_done !== 1'b1) begin fails++; $display("FAIL t4_done1: got %b required 1", upd_done); end
    cnt = 0;
    while (hv_start !== 1'b1 && cnt < 200) begin tick(); cnt++; end
    tests++;
    if (cnt !== 65) begin fails++; $display("FAIL t4_period: got %0d clk required 65", cnt); end
    wait_wait(ok);
    finish_seq(8'h00);
    for (int i = 0; i < 63; i++) tick();
    host_ch = 3'd2; host_data = 10'h155; host_we = 1'b1;
    tick();
    host_we = 1'b0;
    tests++;
    if (host_ack !== 1'b1 || hv_start !== 1'b0) begin
      fails++; $display("FAIL t4_tie_ack: got ack=%b hv=%b required 1 0", host_ack, hv_start);
    end
    cnt = 0;
    while (hv_start !== 1'b1 && cnt < 20) begin tick(); cnt++; end
    tests++;
    if (cnt !== 2) begin fails++; $display("FAIL t4_tie_launch: got %0d clk required 2", cnt); end
    wait_wait(ok);
    finish_seq(8'h00);
    refresh_en = 1'b0;
    tests++;
    if (upd_done !== 1'b1) begin fails++; $display("FAIL t4_done3: got %b required 1", upd_done); end
    cnt = 0;
    for (int i = 0; i < 100; i++) begin tick(); if (hv_start === 1'b1) cnt++; end
    tests++;
    if (cnt !== 0) begin fails++; $display("FAIL t4_single_seq: got %0d start clk required 0", cnt); end
    f_cnt = 3'd2;
    #1;
    tests++;
    if (ram_data_out !== 10'h155) begin fails++; $display("FAIL t4_shadow: got %h required 155", ram_data_out); end
  endtask

  task automatic test_back_to_back();
    int cnt;
    bit ok;
    do_write(3'd3, 10'h0AA);
    wait_wait(ok);
    f_cnt = 3'd4; host_ch = 3'd4; host_data = 10'h3FF; host_we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (host_ack !== 1'b0 || busy !== 1'b1) begin
        fails++; $display("FAIL t5_stall%0d: got ack=%b busy=%b required 0 1", i, host_ack, busy);
      end
    end
    tests++;
    if (ram_data_out !== 10'h000) begin fails++; $display("FAIL t5_no_write: got %h required 000", ram_data_out); end
    finish_seq(8'h00);
    tests++;
    if (upd_done !== 1'b1 || host_ack !== 1'b0) begin
      fails++; $display("FAIL t5_done: got upd=%b ack=%b required 1 0", upd_done, host_ack);
    end
    tick();
    host_we = 1'b0;
    tests++;
    if (host_ack !== 1'b1 || ram_data_out !== 10'h3FF) begin
      fails++; $display("FAIL t5_late_ack: got ack=%b data=%h required 1 3ff", host_ack, ram_data_out);
    end
    cnt = 0;
    while (hv_start !== 1'b1 && cnt < 20) begin tick(); cnt++; end
    tests++;
    if (cnt !== 2) begin fails++; $display("FAIL t5_second_seq: got %0d clk required 2", cnt); end
    wait_wait(ok);
    finish_seq(8'h00);
    tests++;
    if (upd_done !== 1'b1) begin fails++; $display("FAIL t5_done2: got %b required 1", upd_done); end
  endtask

  task automatic test_reset_mid();
    int cnt;
    bit ok;
    do_write(3'd6, 10'h123);
    cnt = 0;
    while (hv_start !== 1'b1 && cnt < 20) begin tick(); cnt++; end
    tick();
    reset = 1'b0;
    #1;
    tests++;
    if (hv_start !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL t6_start_abort: got hv=%b busy=%b required 0 0", hv_start, busy);
    end
    #3;
    reset = 1'b1;
    tick();
    do_write(3'd6, 10'h123);
    wait_wait(ok);
    f_cnt = 3'd6;
    #1;
    reset = 1'b0;
    #1;
    tests++;
    if ({hv_start, busy, ram_data_out} !== 12'h000) begin
      fails++; $display("FAIL t6_wait_abort: got hv=%b busy=%b data=%h required 0 0 000", hv_start, busy, ram_data_out);
    end
    f_cnt = 3'd5;
    #1;
    tests++;
    if (ram_data_out !== 10'h000) begin fails++; $display("FAIL t6_shadow_clr: got %h required 000", ram_data_out); end
    dac_end = 1'b1;
    #2;
    reset = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (upd_done === 1'b1 || hv_start === 1'b1) cnt++;
    end
    dac_end = 1'b0;
    tests++;
    if (cnt !== 0) begin fails++; $display("FAIL t6_no_done: got %0d active clk required 0", cnt); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_update();
    test_retry_fault();
    test_timeout();
    test_refresh();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
